bcd_to_binary: RTL and testbench
================================

# bcd_to_binary

Sequential reverse-double-dabble converter: accepts a packed unsigned BCD number (DIGITS decimal digits) and produces its binary value, one shift-and-correct step per clock. It is the inverse of the team's combinational binary-to-BCD converter. It sits on the input side of the display and keypad path, where decimal operator entry must return to binary for arithmetic. It uses a start/busy/done handshake and rejects malformed BCD.

## Interface
Parameters:
- DIGITS, 3, number of BCD digits in the input.
- BIN_W, 10, binary output width. Must be ≥ ceil(log2(10^DIGITS)) for full range; a smaller value is legal, and out-of-range inputs are then flagged as errors.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- bcd_in  in  4*DIGITS  packed BCD; most significant digit in the top nibble (e.g. hundreds, tens, ones).
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; result valid.
- binary_out  out  BIN_W  converted value; held until the next done.
- err  out  1  the last conversion was invalid; valid alongside done and held until the next done.

## Operation
- Working register: {bcd_sr[4*DIGITS-1:0], bin_sr[BIN_W-1:0]}, plus a step counter of width clog2(BIN_W+1).
- FSM has two states, IDLE and SHIFT.
- IDLE + start=1 at an edge:
  - load bcd_sr ← bcd_in and bin_sr ← 0;
  - latch bad_digit = (any input nibble > 9);
  - counter ← 0; go to SHIFT.
- SHIFT, each cycle:
  - shift the whole register right by 1, so the LSB of bcd_sr enters the MSB of bin_sr;
  - then, for each post-shift nibble, if the nibble ≥ 8, subtract 3;
  - counter increments.
- After the BIN_W-th step, at the same edge:
  - if bad_digit, or if the residual bcd_sr is nonzero (overflow): binary_out ← 0 and err ← 1;
  - otherwise binary_out ← bin_sr and err ← 0;
  - done ← 1; return to IDLE.
- start while in SHIFT is ignored (no queueing). bcd_in is only sampled at the accept edge, so it may change afterwards.
- An invalid input still runs the full BIN_W steps, so latency is data-independent.

## Timing
- Reset values, applied immediately on rst_n low: busy=0, done=0, err=0, binary_out=0, FSM=IDLE, counter=0, working register=0.
- Reset during SHIFT aborts the conversion. No done is issued and previous outputs are cleared.
- busy is registered. It goes high at the accept edge k and low at edge k+BIN_W.
- done is high for exactly the cycle between edges k+BIN_W and k+BIN_W+1. Latency is therefore BIN_W cycles from the accept edge.
- The FSM is IDLE during the done cycle:
  - start high in that cycle is accepted at edge k+BIN_W+1;
  - done falls and busy rises at that same edge;
  - throughput is one conversion per BIN_W+1 cycles.
- binary_out and err change only at done edges.

## Structure
- Package bcd_pkg holds:
  - BCD_DIGIT_W = 4, BCD_MAX_DIGIT = 9, DD_THRESH = 8, DD_CORR = 3;
  - the FSM state enum {IDLE, SHIFT};
  - function bcd_is_valid(nibble).
- Sub-module bcd_digit_sub3: a combinational 4-bit cell (out = in ≥ 8 ? in − 3 : in). It is instantiated DIGITS times via generate and is the mirror of the add-3 cell.
- Top-level bcd_to_binary holds the FSM, counter, working register and output registers.

## Test plan
- Defaults (DIGITS=3, BIN_W=10). Apply 0x000, 0x009, 0x012, 0x045, 0x099, 0x123, 0x255, 0x999, each after done. Required: binary_out = 0, 9, 12, 45, 99, 123, 255, 999; err=0 each time; done exactly 10 cycles after the accept edge.
- Apply 0x1A5 (invalid tens digit). Required: done after 10 cycles, err=1, binary_out=0. A following 0x045 gives err=0 and binary_out=45.
- Parameter set BIN_W=8. Apply 0x255 → 255, err=0. Apply 0x256 → err=1, binary_out=0 (overflow residual).
- Start 0x123, then pulse start with 0x777 on cycle 4 of SHIFT. Required: the second request is ignored; the result is 123 and only one done occurs.
- Back-to-back: hold start high continuously with 0x255 then 0x045 presented. Required: done pulses 11 cycles apart with results 255 then 45; busy is low for exactly the one done cycle.
- Assert rst_n=0 mid-SHIFT on a 0x999 conversion. Required: all outputs are 0 immediately and no done occurs. After release, a fresh 0x999 returns 999.

Source files
------------

// File: rtl/bcd_to_binary_pkg.sv
// Shared constants, FSM state type and digit check for the BCD-to-binary converter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bcd_pkg;

  localparam int           BCD_DIGIT_W   = 4;
  localparam logic [3:0]   BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0]   DD_THRESH     = 4'd8;
  localparam logic [3:0]   DD_CORR       = 4'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A nibble is a legal decimal digit only when it is 0..9.
  function automatic logic bcd_is_valid(input logic [BCD_DIGIT_W-1:0] nibble);
    return (nibble <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble correction cell: subtracts 3 from a nibble that is 8 or more.
// Latency: combinational.
// Backpressure: none; pure function of its input.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // After a right shift a digit of 8+ came from a doubled tens carry; removing 3 restores decimal weight.
  always_comb begin
    dout = din;
    if (din >= DD_THRESH) begin
      dout = din - DD_CORR;
    end
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double dabble), one shift-and-correct step per clock.
// Latency: BIN_W cycles from the accept edge to done; one conversion per BIN_W+1 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              binary_out,
  output logic                          err
);

  localparam int                BCD_W     = BCD_DIGIT_W * DIGITS;
  localparam int                CNT_W     = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(BIN_W - 1);

  state_t                   state_q;
  state_t                   state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [BCD_W-1:0]         bcd_sr;
  logic [BIN_W-1:0]         bin_sr;
  logic                     bad_digit;

  logic [BCD_W+BIN_W-1:0]   shifted;
  logic [BCD_W-1:0]         bcd_corr;
  logic                     in_bad;
  logic                     accept;
  logic                     step;
  logic                     last_step;

  // Whole working register moves right by one; the BCD LSB falls into the binary MSB.
  always_comb begin
    shifted = {bcd_sr, bin_sr} >> 1;
  end

  // One correction cell per digit, applied to the post-shift BCD field.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_sub3 u_sub3 (
        .din  (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (bcd_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Flag any input nibble above 9; latched at accept so the result can be rejected at the end.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_is_valid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
        in_bad = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a conversion always runs exactly BIN_W steps, valid input or not.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)              state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_STEP) state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // FSM outputs: per-cycle control strobes for the datapath and output registers.
  always_comb begin
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        accept = start;
      end
      SHIFT: begin
        step      = 1'b1;
        last_step = (cnt_q == LAST_STEP);
      end
      default: begin
        accept = 1'b0;
      end
    endcase
  end

  // Working register and step counter: load on accept, shift-and-correct while stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_sr    <= '0;
      bin_sr    <= '0;
      bad_digit <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      bcd_sr    <= bcd_in;
      bin_sr    <= '0;
      bad_digit <= in_bad;
      cnt_q     <= '0;
    end else if (step) begin
      bcd_sr    <= bcd_corr;
      bin_sr    <= shifted[BIN_W-1:0];
      cnt_q     <= cnt_q + 1'b1;
    end
  end

  // Handshake and result registers; a nonzero BCD residual means the value did not fit in BIN_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      binary_out <= '0;
      err        <= 1'b0;
    end else begin
      done <= last_step;
      if (accept) begin
        busy <= 1'b1;
      end else if (last_step) begin
        busy <= 1'b0;
      end
      if (last_step) begin
        if (bad_digit || (|bcd_corr)) begin
          binary_out <= '0;
          err        <= 1'b1;
        end else begin
          binary_out <= shifted[BIN_W-1:0];
          err        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: default (BIN_W=10) and narrow (BIN_W=8) instances.
// Inputs driven and outputs sampled on the falling edge.
// Each scenario task does its own comparisons.
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a;
  logic        start_b;
  logic [11:0] bcd_in;

  logic        a_busy, a_done, a_err;
  logic [9:0]  a_bin;
  logic        b_busy, b_done, b_err;
  logic [7:0]  b_bin;

  int total  = 0;
  int passed = 0;

  logic [11:0] vec_in  [8] = '{12'h000, 12'h009, 12'h012, 12'h045, 12'h099, 12'h123, 12'h255, 12'h999};
  logic [9:0]  vec_exp [8] = '{10'd0, 10'd9, 10'd12, 10'd45, 10'd99, 10'd123, 10'd255, 10'd999};

  always #5 clk = ~clk;

  bcd_to_binary #(.DIGITS(3), .BIN_W(10)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .bcd_in     (bcd_in),
    .busy       (a_busy),
    .done       (a_done),
    .binary_out (a_bin),
    .err        (a_err)
  );

  bcd_to_binary #(.DIGITS(3), .BIN_W(8)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .bcd_in     (bcd_in),
    .busy       (b_busy),
    .done       (b_done),
    .binary_out (b_bin),
    .err        (b_err)
  );

  // Stimulus only: runs one conversion and reports latency, result and whether done was a single-cycle pulse.
  task automatic do_conv(input bit use_b, input logic [11:0] val, output int lat,
                         output logic [9:0] res, output logic e, output logic pulse_ok);
    @(negedge clk);
    bcd_in = val;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    bcd_in  = 12'hFFF;
    lat = 0;
    while (!(use_b ? b_done : a_done) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = use_b ? {2'b00, b_bin} : a_bin;
    e   = use_b ? b_err : a_err;
    @(negedge clk);
    pulse_ok = !(use_b ? b_done : a_done);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bcd_in  = 12'h000;
    #12;
    total++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else passed++;
    total++; if (a_done !== 1'b0) $display("FAIL reset_done: got %b want 0", a_done); else passed++;
    total++; if (a_err !== 1'b0) $display("FAIL reset_err: got %b want 0", a_err); else passed++;
    total++; if (a_bin !== 10'd0) $display("FAIL reset_bin: got %0d want 0", a_bin); else passed++;
    total++; if (b_bin !== 8'd0 || b_err !== 1'b0) $display("FAIL reset_b: got bin %0d err %b want 0 0", b_bin, b_err); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_valid();
    int lat; logic [9:0] res; logic e; logic p;
    for (int i = 0; i < 8; i++) begin
      do_conv(1'b0, vec_in[i], lat, res, e, p);
      total++; if (lat !== 10) $display("FAIL valid_lat[%h]: got %0d want 10", vec_in[i], lat); else passed++;
      total++; if (res !== vec_exp[i]) $display("FAIL valid_bin[%h]: got %0d want %0d", vec_in[i], res, vec_exp[i]); else passed++;
      total++; if (e !== 1'b0) $display("FAIL valid_err[%h]: got %b want 0", vec_in[i], e); else passed++;
      total++; if (p !== 1'b1) $display("FAIL valid_pulse[%h]: done high for more than one cycle", vec_in[i]); else passed++;
    end
  endtask

  task automatic test_invalid();
    int lat; logic [9:0] res; logic e; logic p;
    do_conv(1'b0, 12'h1A5, lat, res, e, p);
    total++; if (lat !== 10) $display("FAIL invalid_lat: got %0d want 10", lat); else passed++;
    total++; if (e !== 1'b1) $display("FAIL invalid_err: got %b want 1", e); else passed++;
    total++; if (res !== 10'd0) $display("FAIL invalid_bin: got %0d want 0", res); else passed++;
    do_conv(1'b0, 12'h045, lat, res, e, p);
    total++; if (e !== 1'b0 || res !== 10'd45) $display("FAIL after_invalid: got %0d err %b want 45 err 0", res, e); else passed++;
  endtask

  task automatic test_narrow();
    int lat; logic [9:0] res; logic e; logic p;
    do_conv(1'b1, 12'h255, lat, res, e, p);
    total++; if (lat !== 8) $display("FAIL narrow_lat: got %0d want 8", lat); else passed++;
    total++; if (res !== 10'd255 || e !== 1'b0) $display("FAIL narrow_255: got %0d err %b want 255 err 0", res, e); else passed++;
    do_conv(1'b1, 12'h256, lat, res, e, p);
    total++; if (e !== 1'b1) $display("FAIL narrow_ovf_err: got %b want 1", e); else passed++;
    total++; if (res !== 10'd0) $display("FAIL narrow_ovf_bin: got %0d want 0", res); else passed++;
  endtask

  task automatic test_ignore_start();
    int dones = 0; int first_m = -1; logic [9:0] res = '0; logic e = 1'b1;
    @(negedge clk);
    bcd_in  = 12'h123;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    bcd_in  = 12'h000;
    for (int c = 1; c <= 25; c++) begin
      if (c == 4) begin
        start_a = 1'b1;
        bcd_in  = 12'h777;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
      if (a_done) begin
        dones++;
        if (first_m < 0) begin
          first_m = c;
          res     = a_bin;
          e       = a_err;
        end
      end
    end
    total++; if (dones !== 1) $display("FAIL ignore_dones: got %0d want 1", dones); else passed++;
    total++; if (first_m !== 10) $display("FAIL ignore_lat: got %0d want 10", first_m); else passed++;
    total++; if (res !== 10'd123 || e !== 1'b0) $display("FAIL ignore_bin: got %0d err %b want 123 err 0", res, e); else passed++;
  endtask

  task automatic test_back_to_back();
    int d1 = -1; int d2 = -1; int dones = 0; int busy_low = 0;
    logic [9:0] r1 = '0; logic [9:0] r2 = '0;
    @(negedge clk);
    bcd_in  = 12'h255;
    start_a = 1'b1;
    @(negedge clk);
    total++; if (a_busy !== 1'b1) $display("FAIL b2b_busy_start: got %b want 1", a_busy); else passed++;
    bcd_in = 12'h045;
    for (int m = 1; m <= 30; m++) begin
      @(negedge clk);
      if (m == 11) start_a = 1'b0;
      if (m <= 20 && !a_busy) busy_low++;
      if (a_done) begin
        dones++;
        if (d1 < 0) begin d1 = m; r1 = a_bin; end
        else if (d2 < 0) begin d2 = m; r2 = a_bin; end
      end
    end
    total++; if (dones !== 2) $display("FAIL b2b_dones: got %0d want 2", dones); else passed++;
    total++; if (d1 !== 10) $display("FAIL b2b_first_lat: got %0d want 10", d1); else passed++;
    total++; if (d2 - d1 !== 11) $display("FAIL b2b_spacing: got %0d want 11", d2 - d1); else passed++;
    total++; if (r1 !== 10'd255) $display("FAIL b2b_r1: got %0d want 255", r1); else passed++;
    total++; if (r2 !== 10'd45) $display("FAIL b2b_r2: got %0d want 45", r2); else passed++;
    total++; if (busy_low !== 1) $display("FAIL b2b_busy_low: got %0d cycles want 1", busy_low); else passed++;
  endtask

  task automatic test_reset_mid();
    int dones = 0; int lat; logic [9:0] res; logic e; logic p;
    @(negedge clk);
    bcd_in  = 12'h999;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (a_busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", a_busy); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (a_busy !== 1'b0 || a_done !== 1'b0) $display("FAIL rstmid_ctrl: got busy %b done %b want 0 0", a_busy, a_done); else passed++;
    total++; if (a_bin !== 10'd0 || a_err !== 1'b0) $display("FAIL rstmid_outs: got bin %0d err %b want 0 0", a_bin, a_err); else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (a_done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL rstmid_no_done: got %0d want 0", dones); else passed++;
    do_conv(1'b0, 12'h999, lat, res, e, p);
    total++; if (lat !== 10 || res !== 10'd999 || e !== 1'b0) $display("FAIL rstmid_fresh: got lat %0d bin %0d err %b want 10 999 0", lat, res, e); else passed++;
  endtask

  initial begin
    test_reset();
    test_valid();
    test_invalid();
    test_narrow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
